// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin arbiter between two box-drawing requesters.
// It walks the granted box one pixel per cycle, row-major, and emits framebuffer writes.
module plot_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0,
    input  logic       req1,
    input  logic       erase0,
    input  logic       erase1,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [3:0] w0,
    input  logic [3:0] w1,
    input  logic [3:0] h0,
    input  logic [3:0] h1,
    input  logic [2:0] colour0,
    input  logic [2:0] colour1,
    output logic       grant0,
    output logic       grant1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       plot,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
    localparam logic [8:0] SW = 9'(SCREEN_W);
    localparam logic [7:0] SH = 8'(SCREEN_H);
    state_t state, state_n;
    logic sel, sel_n, last, last_n, win, any_req, finish, drawing, last_col;
    logic [7:0] bx, bx_n, lx, base_x, x_n;
    logic [6:0] by, by_n, ly, base_y, y_n;
    logic [3:0] bw, bw_n, bh, bh_n, lw, lh, dx, dx_n, dy, dy_n, nx, ny, off_x, off_y;
    logic [2:0] bc, bc_n, lc, c_n;
    logic [8:0] sx;
    logic [7:0] sy;
    logic grant0_n, grant1_n, done0_n, done1_n, busy_n, plot_n;
    // Outputs are registered from next-state values, so LOAD already presents pixel (0,0)
    // and the first plot appears in the first DRAW cycle.
    always_comb begin
        any_req = req0 | req1;
        win = !(req0 && (!req1 || last));
        lx = sel ? x1 : x0;
        ly = sel ? y1 : y0;
        lw = sel ? w1 : w0;
        lh = sel ? h1 : h0;
        lc = (sel ? erase1 : erase0) ? BG_COLOUR : (sel ? colour1 : colour0);
        last_col = dx == bw - 4'd1;
        nx = last_col ? 4'd0 : dx + 4'd1;
        ny = last_col ? dy + 4'd1 : dy;
        finish = (state == LOAD && (lw == 4'd0 || lh == 4'd0)) ||
                 (state == DRAW && last_col && dy == bh - 4'd1);
        drawing = (state == LOAD || state == DRAW) && !finish;
        base_x = state == LOAD ? lx : bx;
        base_y = state == LOAD ? ly : by;
        off_x = state == LOAD ? 4'd0 : nx;
        off_y = state == LOAD ? 4'd0 : ny;
        sx = {1'b0, base_x} + {5'b0, off_x};
        sy = {1'b0, base_y} + {4'b0, off_y};
        state_n = state == IDLE ? (any_req ? LOAD : IDLE) : state == DONE ? IDLE : finish ? DONE : DRAW;
        sel_n = (state == IDLE && any_req) ? win : sel;
        last_n = finish ? sel : last;
        bx_n = state == LOAD ? lx : bx;
        by_n = state == LOAD ? ly : by;
        bw_n = state == LOAD ? lw : bw;
        bh_n = state == LOAD ? lh : bh;
        bc_n = state == LOAD ? lc : bc;
        dx_n = state == DRAW ? nx : 4'd0;
        dy_n = state == DRAW ? ny : 4'd0;
        grant0_n = state == IDLE ? any_req && !win : drawing && !sel;
        grant1_n = state == IDLE ? any_req && win : drawing && sel;
        done0_n = finish && !sel;
        done1_n = finish && sel;
        busy_n = state_n != IDLE;
        plot_n = drawing && sx < SW && sy < SH;
        x_n = drawing ? sx[7:0] : x_out;
        y_n = drawing ? sy[6:0] : y_out;
        c_n = drawing ? (state == LOAD ? lc : bc) : colour_out;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            sel <= 1'b0;
            last <= 1'b1;
            bx <= '0;
            by <= '0;
            bw <= '0;
            bh <= '0;
            bc <= '0;
            dx <= '0;
            dy <= '0;
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy <= 1'b0;
            plot <= 1'b0;
            x_out <= '0;
            y_out <= '0;
            colour_out <= '0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            last <= last_n;
            bx <= bx_n;
            by <= by_n;
            bw <= bw_n;
            bh <= bh_n;
            bc <= bc_n;
            dx <= dx_n;
            dy <= dy_n;
            grant0 <= grant0_n;
            grant1 <= grant1_n;
            done0 <= done0_n;
            done1 <= done1_n;
            busy <= busy_n;
            plot <= plot_n;
            x_out <= x_n;
            y_out <= y_n;
            colour_out <= c_n;
        end
    end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: scoreboard bench; expected pixels are queued when a box is requested
// and popped one per DRAW cycle.
module tb_plot_arbiter;
    logic clk = 1'b0, resetn;
    logic req0, req1, erase0, erase1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [3:0] w0, w1, h0, h1;
    logic [2:0] colour0, colour1;
    logic grant0, grant1, done0, done1, busy, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    typedef struct packed {logic p; logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
    pix_t exp_q[$];
    int vectors = 0, miscompares = 0;
    int last_m = 1;

    plot_arbiter dut (
        .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .erase0(erase0), .erase1(erase1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .w0(w0), .w1(w1), .h0(h0), .h1(h1),
        .colour0(colour0), .colour1(colour1), .grant0(grant0), .grant1(grant1),
        .done0(done0), .done1(done1), .busy(busy), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_box(input int x, input int y, input int w, input int h,
                            input logic [2:0] col, input logic er);
        pix_t e;
        logic [8:0] px;
        logic [7:0] py;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                px = 9'(x + i);
                py = 8'(y + j);
                e.p = (x + i < 160) && (y + j < 120);
                e.x = px[7:0];
                e.y = py[6:0];
                e.c = er ? 3'b000 : col;
                exp_q.push_back(e);
            end
    endtask

    task automatic set_req(input int who, input int x, input int y, input int w, input int h,
                           input logic [2:0] col, input logic er);
        if (who == 0) begin
            x0 = 8'(x); y0 = 7'(y); w0 = 4'(w); h0 = 4'(h); colour0 = col; erase0 = er; req0 = 1'b1;
        end else begin
            x1 = 8'(x); y1 = 7'(y); w1 = 4'(w); h1 = 4'(h); colour1 = col; erase1 = er; req1 = 1'b1;
        end
    endtask

    task automatic wait_grant(input int who);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(grant0 | grant1) && lat < 20);
        check("grant_latency", lat, 1);
        check("grant_who", {grant1, grant0}, who ? 2 : 1);
        check("busy_load", busy, 1);
        check("plot_load", plot, 0);
    endtask

    task automatic draw_cycle(input int who);
        pix_t e;
        @(negedge clk);
        e = exp_q.pop_front();
        check("pixel", {plot, x_out, y_out, colour_out}, e);
        check("grant_draw", {grant1, grant0, done1, done0}, who ? 8 : 4);
    endtask

    task automatic serve(input int who, input int n, input bit disturb);
        wait_grant(who);
        for (int k = 0; k < n; k++) begin
            draw_cycle(who);
            if (disturb && k == 0) begin
                req0 = 1'b0; x0 = 8'd0; y0 = 7'd0; w0 = 4'd1; colour0 = 3'b000; erase0 = 1'b1;
            end
        end
        @(negedge clk);
        check("done", {done1, done0}, who ? 2 : 1);
        check("grant_done", {grant1, grant0}, 0);
        check("busy_done", busy, 1);
        check("plot_done", plot, 0);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        last_m = who;
        @(negedge clk);
        check("done_pulse", {done1, done0, busy}, 0);
    endtask

    function automatic int pick(input bit r0, input bit r1);
        return (r0 && (!r1 || last_m == 1)) ? 0 : 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check(tag, {grant1, grant0, done1, done0, busy, plot, x_out, y_out, colour_out}, 0);
    endtask

    initial begin
        int first;
        resetn = 1'b0;
        {req0, req1, erase0, erase1} = '0;
        {x0, x1, y0, y1, w0, w1, h0, h1, colour0, colour1} = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        resetn = 1'b1;

        // Simultaneous requests straight after reset: 0 first, then 1.
        set_req(0, 5, 5, 2, 1, 3'b010, 1'b0);
        set_req(1, 30, 40, 1, 2, 3'b011, 1'b0);
        first = pick(1'b1, 1'b1);
        check("tie_model_first", first, 0);
        if (first == 0) begin push_box(5, 5, 2, 1, 3'b010, 1'b0); push_box(30, 40, 1, 2, 3'b011, 1'b0); end
        else begin push_box(30, 40, 1, 2, 3'b011, 1'b0); push_box(5, 5, 2, 1, 3'b010, 1'b0); end
        serve(first, first ? 2 : 2, 1'b0);
        serve(1 - first, 2, 1'b0);

        set_req(0, 10, 20, 2, 2, 3'b101, 1'b0);
        push_box(10, 20, 2, 2, 3'b101, 1'b0);
        serve(0, 4, 1'b0);

        // Requester 0 was served last, so requester 1 wins this tie.
        set_req(0, 1, 2, 1, 1, 3'b001, 1'b0);
        set_req(1, 3, 4, 2, 1, 3'b100, 1'b0);
        first = pick(1'b1, 1'b1);
        if (first == 0) begin push_box(1, 2, 1, 1, 3'b001, 1'b0); push_box(3, 4, 2, 1, 3'b100, 1'b0); end
        else begin push_box(3, 4, 2, 1, 3'b100, 1'b0); push_box(1, 2, 1, 1, 3'b001, 1'b0); end
        serve(first, first ? 2 : 1, 1'b0);
        serve(1 - first, first ? 1 : 2, 1'b0);

        set_req(1, 50, 60, 3, 1, 3'b111, 1'b1);
        push_box(50, 60, 3, 1, 3'b111, 1'b1);
        serve(1, 3, 1'b0);

        set_req(0, 158, 119, 4, 2, 3'b110, 1'b0);
        push_box(158, 119, 4, 2, 3'b110, 1'b0);
        serve(0, 8, 1'b0);

        set_req(0, 7, 7, 0, 5, 3'b011, 1'b0);
        serve(0, 0, 1'b0);

        // Operands change and req drops mid-draw; the latched box must still complete.
        set_req(0, 60, 30, 3, 2, 3'b110, 1'b0);
        push_box(60, 30, 3, 2, 3'b110, 1'b0);
        serve(0, 6, 1'b1);

        // Reset in the middle of a 4x4 box, then the still-pending request restarts.
        set_req(0, 40, 50, 4, 4, 3'b001, 1'b0);
        push_box(40, 50, 4, 4, 3'b001, 1'b0);
        wait_grant(0);
        repeat (3) draw_cycle(0);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_draw");
        exp_q.delete();
        last_m = 1;
        resetn = 1'b1;
        push_box(40, 50, 4, 4, 3'b001, 1'b0);
        serve(0, 16, 1'b0);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
Parameters:
REQ-001 SCREEN_W, 160, horizontal pixel limit; x >= SCREEN_W is off-screen.
REQ-002 SCREEN_H, 120, vertical pixel limit; y >= SCREEN_H is off-screen.
REQ-003 BG_COLOUR, 3'b000, colour written by erase requests.
Ports:
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 req0 / req1  in  1  requester wants a box drawn; held high until its done pulse.
REQ-007 erase0 / erase1  in  1  1 = paint box in BG_COLOUR, 0 = paint in colourN.
REQ-008 x0 / x1  in  8  box top-left x.
REQ-009 y0 / y1  in  7  box top-left y.
REQ-010 w0 / w1, h0 / h1  in  4  box width/height in pixels (0..15).
REQ-011 colour0 / colour1  in  3  draw colour.
REQ-012 grant0 / grant1  out  1  high while that requester's box is being serviced.
REQ-013 done0 / done1  out  1  one-cycle pulse when that requester's box is finished.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 plot  out  1  framebuffer write enable for the current pixel.
REQ-016 x_out  out  8, y_out  out  7, colour_out  out  3  current pixel address and colour.

Function
REQ-017 Shall implement FSM with states IDLE, LOAD, DRAW, DONE; all outputs registered.
REQ-018 IDLE: if any req high, select winner, go to LOAD next cycle; else stay.
REQ-019 Arbitration: single request wins; both high -> requester not granted last wins (round robin); after reset requester 0 has priority.
REQ-020 LOAD (1 cycle): latch winner's x, y, w, h, colour/erase; assert grantN; clear offset counters dx = dy = 0.
REQ-021 LOAD with w == 0 or h == 0: go directly to DONE, no plot pulses.
REQ-022 DRAW: one pixel per cycle, row-major (dx fastest); x_out = x + dx, y_out = y + dy, colour_out = BG_COLOUR if erase else colour.
REQ-023 DRAW lasts exactly w*h cycles; after pixel (w-1, h-1) go to DONE.
REQ-024 plot = 1 in DRAW only when x + dx < SCREEN_W and y + dy < SCREEN_H (computed 9-bit/8-bit, no wrap); off-screen pixels still consume a cycle with plot = 0.
REQ-025 DONE (1 cycle): pulse doneN for granted requester, deassert grantN, record it as last granted, return to IDLE.
REQ-026 req inputs and requester operands shall be ignored in LOAD+1 through DONE; changes mid-draw do not affect the box in progress.
REQ-027 Dropping reqN mid-draw shall not abort; box completes and doneN still pulses.
REQ-028 Requester shall deassert req on the cycle it sees done; a req still high in the following IDLE is a new request.
REQ-029 Latency: req sampled in IDLE at cycle N -> grant at N+1, first plot at N+2, done at N+2+w*h.
REQ-030 At most one grant and one done high at any time; plot = 0 outside DRAW.

Reset
REQ-031 resetn = 0 at a clock edge: state IDLE, grant0/1 = 0, done0/1 = 0, busy = 0, plot = 0, x_out = 0, y_out = 0, colour_out = 0, counters 0, last-granted = requester 1 (so requester 0 wins first tie).
REQ-032 Reset mid-DRAW shall abort immediately with no done pulse; the aborted request is re-served only if req is high after reset.

Verification
REQ-033 req0 only, x0=10, y0=20, w0=2, h0=2, colour0=3'b101 -> plot at (10,20),(11,20),(10,21),(11,21) on cycles N+2..N+5, colour 101, done0 at N+6.
REQ-034 req0 and req1 high same cycle after reset -> requester 0 served first, then requester 1; repeat simultaneous -> order alternates 1 then 0 subsequent tie.
REQ-035 req1 erase1=1, colour1=3'b111, w1=3, h1=1 -> three plots with colour_out = 000, done1 after 3 DRAW cycles.
REQ-036 x0=158, y0=119, w0=4, h0=2 -> 8 DRAW cycles, plot high only for (158,119),(159,119); done0 at N+10.
REQ-037 w0=0, h0=5 -> no plot, done0 at N+2, busy high N+1..N+2.
REQ-038 resetn low during DRAW of a 4x4 box -> next cycle all outputs at reset values, no done0; req0 still high -> box restarts from (x0,y0).
